if_fetch_buffer: RTL and testbench

//  Decoupling buffer between IF2 and the IF/ID register (if2id_reg).

---
 rtl/riscv_pkg.sv | 30 +++
 rtl/fetch_fifo.sv | 75 +++++++
 rtl/if_fetch_buffer.sv | 85 ++++++++
 tb/tb_if_fetch_buffer.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
`default_nettype none
// riscv_pkg: fetch-path types and constants shared by the fetch buffer.
// Rev 1.0
package riscv_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] instruction;
  } fetch_entry_t;

  typedef enum logic [0:0] {
    ST_RUN    = 1'b0,
    ST_SQUASH = 1'b1
  } squash_state_e;

  // Reset image of a storage slot: a NOP at pc 0 that is harmless if consumed.
  function automatic fetch_entry_t fetch_reset_entry();
    fetch_entry_t e;
    e.pc          = '0;
    e.pc_plus4    = XLEN'(4);
    e.instruction = NOP_INST;
    return e;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// fetch_fifo: DEPTH-entry register FIFO of fetch_entry_t with synchronous clear.
// Rev 1.0
module fetch_fifo
  import riscv_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  fetch_entry_t             wr_entry_i,
  output fetch_entry_t             rd_entry_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  fetch_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             rd_en;
  logic             wr_en;

  assign rd_en = pop_i & (count_q != '0);
  // A write into a full FIFO is only legal when the head leaves in the same cycle.
  assign wr_en = push_i & ((count_q != (PTR_W+1)'(DEPTH)) | rd_en);

  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (clr_i) begin
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (wr_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (rd_en) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({wr_en, rd_en})
        2'b10:   count_d = count_q + (PTR_W+1)'(1);
        2'b01:   count_d = count_q - (PTR_W+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= fetch_reset_entry();
    end else if (wr_en && !clr_i) begin
      mem_q[wr_ptr_q] <= wr_entry_i;
    end
  end

  assign rd_entry_o = mem_q[rd_ptr_q];
  assign count_o    = count_q;

endmodule
`default_nettype wire

// File: rtl/if_fetch_buffer.sv
`default_nettype none
// if_fetch_buffer: IF2 -> IF/ID decoupling buffer with credit throttle and redirect squash.
// Rev 1.0
module if_fetch_buffer
  import riscv_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,  // must equal riscv_pkg::XLEN
  parameter int unsigned DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush_i,
  input  logic                  valid_i,
  input  logic [DATA_WIDTH-1:0] pc_i,
  input  logic [DATA_WIDTH-1:0] pc_plus4_i,
  input  logic [DATA_WIDTH-1:0] instruction_i,
  output logic                  fetch_en_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [DATA_WIDTH-1:0] pc_o,
  output logic [DATA_WIDTH-1:0] pc_plus4_o,
  output logic [DATA_WIDTH-1:0] instruction_o
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  squash_state_e    state_q, state_d;
  logic             push;
  logic             pop;
  logic [CNT_W-1:0] count;
  logic [CNT_W:0]   credit_sum;
  fetch_entry_t     wr_entry;
  fetch_entry_t     head;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_RUN;
    else        state_q <= state_d;
  end

  // SQUASH covers the cycle after a redirect, when IF2 returns the wrong-path fetch.
  always_comb begin
    state_d = state_q;
    push    = 1'b0;
    case (state_q)
      ST_RUN: begin
        push = valid_i & ~flush_i;
        if (flush_i) state_d = ST_SQUASH;
      end
      ST_SQUASH: begin
        if (!flush_i) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  assign pop = valid_o & ready_i & ~flush_i;

  assign wr_entry.pc          = pc_i;
  assign wr_entry.pc_plus4    = pc_plus4_i;
  assign wr_entry.instruction = instruction_i;

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_i      (flush_i),
    .push_i     (push),
    .pop_i      (pop),
    .wr_entry_i (wr_entry),
    .rd_entry_o (head),
    .count_o    (count)
  );

  // Registered count plus the in-flight IF2 fetch: no ready_i/flush_i path to IF1.
  assign credit_sum = {1'b0, count} + {{CNT_W{1'b0}}, valid_i};
  assign fetch_en_o = credit_sum < (CNT_W+1)'(DEPTH);

  assign valid_o       = (count != '0);
  assign pc_o          = head.pc;
  assign pc_plus4_o    = head.pc_plus4;
  assign instruction_o = head.instruction;

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_buffer.sv
`default_nettype none
// tb_if_fetch_buffer: directed and randomized checks against a queue-based model of the buffer.
module tb_if_fetch_buffer;

  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          flush_i = 1'b0;
  logic          valid_i = 1'b0;
  logic          ready_i = 1'b0;
  logic [DW-1:0] pc_i = '0;
  logic [DW-1:0] pc_plus4_i = '0;
  logic [DW-1:0] instruction_i = '0;
  logic          fetch_en_o;
  logic          valid_o;
  logic [DW-1:0] pc_o;
  logic [DW-1:0] pc_plus4_o;
  logic [DW-1:0] instruction_o;

  always #5 clk = ~clk;

  if_fetch_buffer #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .flush_i       (flush_i),
    .valid_i       (valid_i),
    .pc_i          (pc_i),
    .pc_plus4_i    (pc_plus4_i),
    .instruction_i (instruction_i),
    .fetch_en_o    (fetch_en_o),
    .valid_o       (valid_o),
    .ready_i       (ready_i),
    .pc_o          (pc_o),
    .pc_plus4_o    (pc_plus4_o),
    .instruction_o (instruction_o)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  ent_t        q[$];        // entries the buffer should hold, head first
  bit          squash;      // next IF2 fetch is wrong-path
  bit          want;        // IF1 wishes to issue this cycle
  bit          raw;         // stimulus drives valid_i directly, bypassing IF1 model
  logic [31:0] if1_pc;
  logic [31:0] redirect;
  int          n_total = 0;
  int          n_bad = 0;

  function automatic logic [31:0] imem(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
  endfunction

  task automatic set_in(input bit v, input logic [31:0] a);
    valid_i       = v;
    pc_i          = a;
    pc_plus4_i    = a + 32'd4;
    instruction_i = imem(a);
  endtask

  // Advance one clock: update the reference queue and the IF1/IF2 pipe model.
  task automatic tick();
    bit          push, pop, issue;
    logic [31:0] issued_pc;
    push = valid_i && !flush_i && !squash;
    pop  = (q.size() != 0) && ready_i && !flush_i;
    n_total++;
    assert (!push || pop || q.size() < DEPTH)
    else begin
      n_bad++;
      $display("FAIL overflow: push into full buffer, occupancy=%0d limit=%0d", q.size(), DEPTH);
    end
    issue     = !raw && want && (fetch_en_o === 1'b1);
    issued_pc = if1_pc;
    if (flush_i) q.delete();
    else begin
      if (pop)  void'(q.pop_front());
      if (push) q.push_back('{pc: pc_i, inst: instruction_i});
    end
    squash = flush_i;
    if (!raw) begin
      if (flush_i)    if1_pc = redirect;
      else if (issue) if1_pc = if1_pc + 32'd4;
    end
    @(posedge clk);
    #1;
    if (!raw) set_in(issue, issued_pc);
  endtask

  task automatic drain();
    int n = 0;
    flush_i = 1'b0; ready_i = 1'b1; want = 1'b0;
    while ((q.size() != 0 || valid_i || squash) && n < 50) begin
      @(negedge clk);
      tick();
      n++;
    end
    n_total++;
    if (n >= 50) begin n_bad++; $display("FAIL drain_timeout got=%0d entries need=0", q.size()); end
  endtask

  task automatic test_reset();
    int n = 0;
    ready_i = 1'b0; want = 1'b1; flush_i = 1'b0; if1_pc = 32'h20;
    while (!(q.size() == 3) && n < 20) begin
      @(negedge clk);
      n_total++;
      if (valid_o !== (q.size() != 0)) begin n_bad++; $display("FAIL reset_fill valid_o got=%b need=%b", valid_o, q.size() != 0); end
      tick();
      n++;
    end
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    set_in(1'b0, 32'h0);
    #1;
    n_total++;
    if (valid_o !== 1'b0) begin n_bad++; $display("FAIL reset_valid got=%b need=0", valid_o); end
    n_total++;
    if (pc_o !== 32'h0 || pc_plus4_o !== 32'h4 || instruction_o !== 32'h13) begin
      n_bad++; $display("FAIL reset_head got=%h/%h/%h need=0/4/13", pc_o, pc_plus4_o, instruction_o);
    end
    n_total++;
    if (fetch_en_o !== 1'b1) begin n_bad++; $display("FAIL reset_fetch_en got=%b need=1", fetch_en_o); end
    q.delete(); squash = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    n_total++;
    if (fetch_en_o !== 1'b1 || valid_o !== 1'b0) begin
      n_bad++; $display("FAIL reset_release got fetch_en=%b valid=%b need 1/0", fetch_en_o, valid_o);
    end
  endtask

  task automatic test_stream();
    logic [31:0] exp_pc = 32'h0;
    drain();
    if1_pc = 32'h0; want = 1'b1; ready_i = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      n_total++;
      if (valid_o !== (c >= 2)) begin n_bad++; $display("FAIL stream_valid c=%0d got=%b need=%b", c, valid_o, c >= 2); end
      n_total++;
      if (fetch_en_o !== 1'b1) begin n_bad++; $display("FAIL stream_fetch_en c=%0d got=%b need=1", c, fetch_en_o); end
      if (valid_o === 1'b1) begin
        n_total++;
        if (pc_o !== exp_pc || instruction_o !== imem(exp_pc) || pc_plus4_o !== exp_pc + 4) begin
          n_bad++; $display("FAIL stream_head got=%h/%h need=%h/%h", pc_o, instruction_o, exp_pc, imem(exp_pc));
        end
        exp_pc = exp_pc + 4;
      end
      tick();
    end
  endtask

  task automatic test_stall();
    logic [31:0] exp_pc = 32'h0;
    int n = 0;
    drain();
    if1_pc = 32'h0; want = 1'b1; ready_i = 1'b0;
    while (q.size() < DEPTH && n < 20) begin
      @(negedge clk);
      n_total++;
      if (fetch_en_o !== ((q.size() + int'(valid_i)) < DEPTH)) begin
        n_bad++; $display("FAIL stall_fetch_en got=%b need=%b", fetch_en_o, (q.size() + int'(valid_i)) < DEPTH);
      end
      tick();
      n++;
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_total++;
      if (fetch_en_o !== 1'b0 || valid_o !== 1'b1 || pc_o !== 32'h0) begin
        n_bad++; $display("FAIL stall_full got fetch_en=%b valid=%b pc=%h need 0/1/0", fetch_en_o, valid_o, pc_o);
      end
      tick();
    end
    ready_i = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      n_total++;
      if (valid_o !== (q.size() != 0)) begin n_bad++; $display("FAIL stall_drain_valid got=%b need=%b", valid_o, q.size() != 0); end
      n_total++;
      if (fetch_en_o !== ((q.size() + int'(valid_i)) < DEPTH)) begin
        n_bad++; $display("FAIL stall_drain_fetch_en got=%b need=%b", fetch_en_o, (q.size() + int'(valid_i)) < DEPTH);
      end
      if (valid_o === 1'b1) begin
        n_total++;
        if (pc_o !== exp_pc || instruction_o !== imem(exp_pc)) begin
          n_bad++; $display("FAIL stall_order got=%h need=%h", pc_o, exp_pc);
        end
        exp_pc = exp_pc + 4;
      end
      tick();
    end
  endtask

  task automatic test_flush();
    int n = 0;
    drain();
    if1_pc = 32'h8; want = 1'b1; ready_i = 1'b0;
    while (!(q.size() == 2 && valid_i) && n < 20) begin
      @(negedge clk);
      tick();
      n++;
    end
    n_total++;
    if (pc_i !== 32'h10 || valid_o !== 1'b1) begin
      n_bad++; $display("FAIL flush_setup got pc_i=%h valid=%b need 10/1", pc_i, valid_o);
    end
    flush_i = 1'b1; ready_i = 1'b1; redirect = 32'h100;
    @(negedge clk);
    tick();
    flush_i = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_total++;
      if (valid_o !== (c == 2)) begin n_bad++; $display("FAIL flush_valid c=%0d got=%b need=%b", c, valid_o, c == 2); end
      if (c == 2) begin
        n_total++;
        if (pc_o !== 32'h100 || instruction_o !== imem(32'h100)) begin
          n_bad++; $display("FAIL flush_target got=%h need=100", pc_o);
        end
      end
      tick();
    end
  endtask

  task automatic test_back_to_back_flush();
    drain();
    if1_pc = 32'h40; want = 1'b1; ready_i = 1'b1;
    for (int c = 0; c < 4; c++) begin @(negedge clk); tick(); end
    flush_i = 1'b1; redirect = 32'h200;
    @(negedge clk); tick();
    redirect = 32'h300;
    @(negedge clk);
    n_total++;
    if (valid_o !== 1'b0) begin n_bad++; $display("FAIL b2b_mid_valid got=%b need=0", valid_o); end
    tick();
    flush_i = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      n_total++;
      if (valid_o !== (k >= 2)) begin n_bad++; $display("FAIL b2b_valid k=%0d got=%b need=%b", k, valid_o, k >= 2); end
      if (k >= 2) begin
        n_total++;
        if (pc_o !== 32'h300 + 32'(4 * (k - 2))) begin
          n_bad++; $display("FAIL b2b_pc k=%0d got=%h need=%h", k, pc_o, 32'h300 + 32'(4 * (k - 2)));
        end
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] nxt = 32'h400;
    drain();
    raw = 1'b1; ready_i = 1'b0;
    for (int c = 0; c < 3; c++) begin
      set_in(1'b1, nxt); nxt = nxt + 4;
      @(negedge clk); tick();
    end
    ready_i = 1'b1;
    for (int k = 0; k < 7; k++) begin
      set_in(k < 6, nxt); nxt = nxt + 4;
      @(negedge clk);
      n_total++;
      if (valid_o !== 1'b1 || pc_o !== 32'h400 + 32'(4 * k) || instruction_o !== imem(32'h400 + 32'(4 * k))) begin
        n_bad++; $display("FAIL pushpop k=%0d got valid=%b pc=%h need 1/%h", k, valid_o, pc_o, 32'h400 + 32'(4 * k));
      end
      n_total++;
      if (fetch_en_o !== ((q.size() + int'(valid_i)) < DEPTH)) begin
        n_bad++; $display("FAIL pushpop_fetch_en k=%0d got=%b need=%b", k, fetch_en_o, (q.size() + int'(valid_i)) < DEPTH);
      end
      tick();
    end
    raw = 1'b0;
    set_in(1'b0, 32'h0);
  endtask

  task automatic test_random();
    drain();
    if1_pc = 32'h1000;
    for (int c = 0; c < 400; c++) begin
      ready_i  = ($urandom_range(0, 3) != 0);
      want     = ($urandom_range(0, 3) != 0);
      flush_i  = ($urandom_range(0, 19) == 0);
      redirect = {14'h0, 16'($urandom_range(0, 16'hFFFF)), 2'b00};
      @(negedge clk);
      n_total++;
      if (valid_o !== (q.size() != 0)) begin n_bad++; $display("FAIL rand_valid c=%0d got=%b need=%b", c, valid_o, q.size() != 0); end
      n_total++;
      if (fetch_en_o !== ((q.size() + int'(valid_i)) < DEPTH)) begin
        n_bad++; $display("FAIL rand_fetch_en c=%0d got=%b need=%b", c, fetch_en_o, (q.size() + int'(valid_i)) < DEPTH);
      end
      if (q.size() != 0) begin
        n_total++;
        if (pc_o !== q[0].pc || pc_plus4_o !== q[0].pc + 4 || instruction_o !== q[0].inst) begin
          n_bad++; $display("FAIL rand_head c=%0d got=%h/%h need=%h/%h", c, pc_o, instruction_o, q[0].pc, q[0].inst);
        end
      end
      tick();
    end
    flush_i = 1'b0;
  endtask

  initial begin
    squash = 1'b0; want = 1'b0; raw = 1'b0; if1_pc = '0; redirect = '0;
    set_in(1'b0, 32'h0);
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    test_reset();
    test_stream();
    test_stall();
    test_flush();
    test_back_to_back_flush();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
